// File: rtl/fb_rect_writer.sv
// fb_rect_writer: filled-rectangle drawing engine on the write port of the
// VGA framebuffer. Accepts one command over valid/ready, clips it to the
// screen and writes it row-major, one pixel per clock, with no bubbles.
// Optional feature: define FB_CLEAR_ON_RST_EN to zero the whole framebuffer
// after every reset before the first command is accepted.
module fb_rect_writer #(
    parameter int RES_X      = 320,
    parameter int RES_Y      = 240,
    parameter int MEM_WIDTH  = 8,
    parameter int MEM_DEPTH  = RES_X * RES_Y,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int X_BITS     = $clog2(RES_X),
    parameter int Y_BITS     = $clog2(RES_Y)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [X_BITS-1:0]     cmd_x,
    input  logic [Y_BITS-1:0]     cmd_y,
    input  logic [X_BITS:0]       cmd_w,
    input  logic [Y_BITS:0]       cmd_h,
    input  logic [MEM_WIDTH-1:0]  cmd_color,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]  din,
    output logic                  wen
);

    localparam logic [X_BITS+1:0]   RES_X_W = (X_BITS+2)'(RES_X);
    localparam logic [Y_BITS+1:0]   RES_Y_W = (Y_BITS+2)'(RES_Y);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(RES_X);

`ifdef FB_CLEAR_ON_RST_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE, S_CLEAR} state_t;
    localparam logic [ADDR_WIDTH:0] CLR_END = (ADDR_WIDTH+1)'(MEM_DEPTH);
    logic [ADDR_WIDTH:0] clr_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;
`endif

    state_t state;

    // Latched command
    logic [X_BITS-1:0]    x_q;
    logic [Y_BITS-1:0]    y_q;
    logic [X_BITS:0]      w_q;
    logic [Y_BITS:0]      h_q;
    logic [MEM_WIDTH-1:0] color_q;

    // Draw walk state
    logic [X_BITS+1:0]    col, x_end;
    logic [Y_BITS+1:0]    row, y_end;
    logic [ADDR_WIDTH-1:0] row_base;

    // Combinational helpers
    logic [X_BITS+1:0]    x_sum, x_end_c, col_next;
    logic [Y_BITS+1:0]    y_sum, y_end_c, row_next;
    logic                 empty_c;
    logic [ADDR_WIDTH-1:0] setup_base, next_base, first_addr, row_addr;

    // Clipping, emptiness and address arithmetic; the only multiply is the
    // one-off row base in SETUP, every pixel address after that is incremental
    always_comb begin
        x_sum      = {2'b00, x_q} + {1'b0, w_q};
        y_sum      = {2'b00, y_q} + {1'b0, h_q};
        x_end_c    = (x_sum > RES_X_W) ? RES_X_W : x_sum;
        y_end_c    = (y_sum > RES_Y_W) ? RES_Y_W : y_sum;
        empty_c    = ({2'b00, x_q} >= RES_X_W) || ({2'b00, y_q} >= RES_Y_W) ||
                     (w_q == '0) || (h_q == '0);
        setup_base = ADDR_WIDTH'(y_q) * ROW_STEP;
        first_addr = setup_base + ADDR_WIDTH'(x_q);
        next_base  = row_base + ROW_STEP;
        row_addr   = next_base + ADDR_WIDTH'(x_q);
        col_next   = col + 1'b1;
        row_next   = row + 1'b1;
    end

    // Command FSM with registered handshake, status and write-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef FB_CLEAR_ON_RST_EN
            state   <= S_CLEAR;
            clr_cnt <= '0;
`else
            state   <= S_IDLE;
`endif
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wen       <= 1'b0;
            mem_addr  <= '0;
            din       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    wen  <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        x_q       <= cmd_x;
                        y_q       <= cmd_y;
                        w_q       <= cmd_w;
                        h_q       <= cmd_h;
                        color_q   <= cmd_color;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_SETUP: begin
                    row_base <= setup_base;
                    col      <= {2'b00, x_q};
                    row      <= {2'b00, y_q};
                    x_end    <= x_end_c;
                    y_end    <= y_end_c;
                    if (empty_c) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wen      <= 1'b1;
                        mem_addr <= first_addr;
                        din      <= color_q;
                        state    <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    // Next-pixel decision is made while the current pixel is
                    // on the port, so row wraps cost no idle cycle
                    if (col_next < x_end) begin
                        col      <= col_next;
                        mem_addr <= mem_addr + 1'b1;
                    end else if (row_next < y_end) begin
                        col      <= {2'b00, x_q};
                        row      <= row_next;
                        row_base <= next_base;
                        mem_addr <= row_addr;
                    end else begin
                        wen   <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
`ifdef FB_CLEAR_ON_RST_EN
                S_CLEAR: begin
                    if (clr_cnt < CLR_END) begin
                        wen      <= 1'b1;
                        busy     <= 1'b1;
                        din      <= '0;
                        mem_addr <= clr_cnt[ADDR_WIDTH-1:0];
                        clr_cnt  <= clr_cnt + 1'b1;
                    end else begin
                        wen       <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Testbench for fb_rect_writer: scoreboard of expected framebuffer writes,
// filled when each command is driven and drained by a write-port monitor.
module tb_fb_rect_writer;

    localparam int RES_X = 320;
    localparam int RES_Y = 240;
    localparam int DEPTH = RES_X * RES_Y;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [8:0]  cmd_x = '0;
    logic [7:0]  cmd_y = '0;
    logic [9:0]  cmd_w = '0;
    logic [8:0]  cmd_h = '0;
    logic [7:0]  cmd_color = '0;
    logic        cmd_ready, busy, done, wen;
    logic [16:0] mem_addr;
    logic [7:0]  din;

    fb_rect_writer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .busy(busy), .done(done),
        .mem_addr(mem_addr), .din(din), .wen(wen)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int compared = 0;
    int mismatched = 0;
    int mon_prints = 0;
    int exp_addr[$];
    int exp_din[$];
    int wen_count = 0, done_count = 0;
    int first_wen_cyc = 0, last_wen_cyc = 0, done_cyc = 0;
    logic wen_prev = 1'b0;
    logic ready_at_done = 1'b0, busy_at_done = 1'b0;
    int ea, ed;

    // Write-port monitor: drains the scoreboard and records timing
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            wen_count++;
            if (wen_prev !== 1'b1) first_wen_cyc = cyc;
            last_wen_cyc = cyc;
            compared++;
            if (exp_addr.size() == 0) begin
                mismatched++;
                if (mon_prints < 20) $display("FAIL unexpected_write: addr=%0d din=%0h, none required", mem_addr, din);
                mon_prints++;
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_din.pop_front();
                if (mem_addr !== 17'(ea) || din !== 8'(ed)) begin
                    mismatched++;
                    if (mon_prints < 20) $display("FAIL write_data: addr=%0d din=%0h, required addr=%0d din=%0h", mem_addr, din, ea, ed);
                    mon_prints++;
                end
            end
        end
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
            ready_at_done = cmd_ready;
            busy_at_done = busy;
        end
        wen_prev = wen;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_rect(input int x, input int y, input int w, input int h, input int c);
        int xe, ye;
        xe = (x + w > RES_X) ? RES_X : x + w;
        ye = (y + h > RES_Y) ? RES_Y : y + h;
        for (int r = y; r < ye; r++)
            for (int col = x; col < xe; col++) begin
                exp_addr.push_back(r * RES_X + col);
                exp_din.push_back(c);
            end
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < limit) begin tick(); n++; end
        if (cmd_ready !== 1'b1) begin
            compared++; mismatched++;
            $display("FAIL wait_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
    endtask

    task automatic issue(input int x, input int y, input int w, input int h, input int c, output int acc);
        wait_ready(200);
        cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 10'(w); cmd_h = 9'(h); cmd_color = 8'(c);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int start, input int limit);
        int n = 0;
        while (done_count == start && n < limit) begin tick(); n++; end
        compared++;
        if (done_count != start + 1) begin
            mismatched++;
            $display("FAIL done_pulse: got %0d pulses, required 1", done_count - start);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        compared += 6;
        if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL rst_cmd_ready: got %b required 0", cmd_ready); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b required 0", done); end
        if (wen !== 1'b0) begin mismatched++; $display("FAIL rst_wen: got %b required 0", wen); end
        if (mem_addr !== 17'd0) begin mismatched++; $display("FAIL rst_addr: got %0d required 0", mem_addr); end
        if (din !== 8'd0) begin mismatched++; $display("FAIL rst_din: got %0h required 0", din); end
`ifdef FB_CLEAR_ON_RST_EN
        for (int i = 0; i < DEPTH; i++) begin exp_addr.push_back(i); exp_din.push_back(0); end
        rst = 1'b0;
        wait_ready(DEPTH + 20);
        compared++;
        if (exp_addr.size() != 0) begin mismatched++; $display("FAIL clear_writes: %0d outstanding, required 0", exp_addr.size()); end
`else
        rst = 1'b0;
        tick();
        compared += 2;
        if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL post_rst_ready: got %b required 1", cmd_ready); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL post_rst_busy: got %b required 0", busy); end
`endif
    endtask

    task automatic test_single();
        int acc, d0, w0;
        d0 = done_count; w0 = wen_count;
        push_rect(10, 20, 3, 2, 'h30);
        issue(10, 20, 3, 2, 'h30, acc);
        wait_done(d0, 50);
        compared += 6;
        if (first_wen_cyc != acc + 1) begin mismatched++; $display("FAIL single_latency: first wen cycle %0d required %0d", first_wen_cyc, acc + 1); end
        if (wen_count - w0 != 6) begin mismatched++; $display("FAIL single_count: got %0d writes required 6", wen_count - w0); end
        if (done_cyc != last_wen_cyc + 1) begin mismatched++; $display("FAIL single_done_pos: done cycle %0d required %0d", done_cyc, last_wen_cyc + 1); end
        if (ready_at_done !== 1'b0) begin mismatched++; $display("FAIL single_ready_in_done: got %b required 0", ready_at_done); end
        if (busy_at_done !== 1'b1) begin mismatched++; $display("FAIL single_busy_in_done: got %b required 1", busy_at_done); end
        if (exp_addr.size() != 0) begin mismatched++; $display("FAIL single_drain: %0d outstanding required 0", exp_addr.size()); end
        tick();
        compared += 2;
        if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL single_ready_after: got %b required 1", cmd_ready); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_clip();
        int acc, d0, w0;
        d0 = done_count; w0 = wen_count;
        push_rect(318, 239, 5, 4, 'h0C);
        issue(318, 239, 5, 4, 'h0C, acc);
        wait_done(d0, 50);
        compared += 3;
        if (wen_count - w0 != 2) begin mismatched++; $display("FAIL clip_count: got %0d writes required 2", wen_count - w0); end
        if (done_cyc != last_wen_cyc + 1) begin mismatched++; $display("FAIL clip_done_pos: done cycle %0d required %0d", done_cyc, last_wen_cyc + 1); end
        if (exp_addr.size() != 0) begin mismatched++; $display("FAIL clip_drain: %0d outstanding required 0", exp_addr.size()); end
    endtask

    task automatic test_empty();
        int acc, d0, w0;
        int ex[2] = '{0, 320};
        int ew[2] = '{0, 4};
        for (int i = 0; i < 2; i++) begin
            d0 = done_count; w0 = wen_count;
            issue(ex[i], 0, ew[i], 4, 'h11, acc);
            wait_done(d0, 20);
            compared += 2;
            if (done_cyc != acc + 1) begin mismatched++; $display("FAIL empty%0d_done_pos: done cycle %0d required %0d", i, done_cyc, acc + 1); end
            if (wen_count != w0) begin mismatched++; $display("FAIL empty%0d_count: got %0d writes required 0", i, wen_count - w0); end
        end
    endtask

    task automatic test_full();
        int acc, d0, w0;
        d0 = done_count; w0 = wen_count;
        push_rect(0, 0, 320, 240, 'h3F);
        issue(0, 0, 320, 240, 'h3F, acc);
        wait_done(d0, DEPTH + 50);
        compared += 4;
        if (wen_count - w0 != DEPTH) begin mismatched++; $display("FAIL full_count: got %0d writes required %0d", wen_count - w0, DEPTH); end
        if (last_wen_cyc - first_wen_cyc != DEPTH - 1) begin mismatched++; $display("FAIL full_contiguous: span %0d required %0d", last_wen_cyc - first_wen_cyc, DEPTH - 1); end
        if (first_wen_cyc != acc + 1) begin mismatched++; $display("FAIL full_latency: first wen cycle %0d required %0d", first_wen_cyc, acc + 1); end
        if (exp_addr.size() != 0) begin mismatched++; $display("FAIL full_drain: %0d outstanding required 0", exp_addr.size()); end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, d0, done1, rdy_cyc, n;
        d0 = done_count;
        push_rect(2, 3, 4, 1, 'h05);
        push_rect(50, 60, 2, 2, 'h0A);
        wait_ready(200);
        cmd_x = 9'd2; cmd_y = 8'd3; cmd_w = 10'd4; cmd_h = 9'd1; cmd_color = 8'h05;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        acc1 = cyc;
        cmd_x = 9'd50; cmd_y = 8'd60; cmd_w = 10'd2; cmd_h = 9'd2; cmd_color = 8'h0A;
        n = 0;
        do begin tick(); n++; end while (cmd_ready !== 1'b1 && n < 100);
        rdy_cyc = cyc;
        done1 = done_cyc;
        compared += 2;
        if (done_count != d0 + 1) begin mismatched++; $display("FAIL b2b_first_done: got %0d pulses required 1", done_count - d0); end
        if (rdy_cyc != done1 + 1) begin mismatched++; $display("FAIL b2b_ready_rise: cycle %0d required %0d", rdy_cyc, done1 + 1); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc2 = cyc;
        wait_done(d0 + 1, 50);
        compared += 3;
        if (acc2 != done1 + 2) begin mismatched++; $display("FAIL b2b_accept: cycle %0d required %0d", acc2, done1 + 2); end
        if (first_wen_cyc != acc2 + 1) begin mismatched++; $display("FAIL b2b_latency: first wen cycle %0d required %0d", first_wen_cyc, acc2 + 1); end
        if (exp_addr.size() != 0) begin mismatched++; $display("FAIL b2b_drain: %0d outstanding required 0", exp_addr.size()); end
        if (acc1 <= 0) $display("b2b note: first accept at cycle %0d", acc1);
    endtask

    task automatic test_mid_reset();
        int acc, d0, w0, n;
        d0 = done_count; w0 = wen_count;
        for (int i = 0; i < 3; i++) begin exp_addr.push_back(100 * RES_X + 100 + i); exp_din.push_back('h2A); end
        issue(100, 100, 4, 4, 'h2A, acc);
        n = 0;
        while (wen_count - w0 < 3 && n < 50) begin tick(); n++; end
        rst = 1'b1;
        tick();
        compared += 2;
        if (wen !== 1'b0) begin mismatched++; $display("FAIL midrst_wen: got %b required 0", wen); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b required 0", busy); end
        tick();
        compared += 2;
        if (wen_count - w0 != 3) begin mismatched++; $display("FAIL midrst_count: got %0d writes required 3", wen_count - w0); end
        if (exp_addr.size() != 0) begin mismatched++; $display("FAIL midrst_drain: %0d outstanding required 0", exp_addr.size()); end
`ifdef FB_CLEAR_ON_RST_EN
        for (int i = 0; i < DEPTH; i++) begin exp_addr.push_back(i); exp_din.push_back(0); end
        rst = 1'b0;
        wait_ready(DEPTH + 20);
        compared++;
        if (exp_addr.size() != 0) begin mismatched++; $display("FAIL midrst_clear: %0d outstanding required 0", exp_addr.size()); end
`else
        rst = 1'b0;
        tick();
        compared++;
        if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready: got %b required 1", cmd_ready); end
`endif
        repeat (3) tick();
        compared++;
        if (done_count != d0) begin mismatched++; $display("FAIL midrst_no_done: got %0d pulses required 0", done_count - d0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clip();
        test_empty();
`ifndef FB_CLEAR_ON_RST_EN
        test_full();
`endif
        test_back_to_back();
        test_mid_reset();
        repeat (5) tick();
        compared++;
        if (exp_addr.size() != 0) begin mismatched++; $display("FAIL final_drain: %0d outstanding required 0", exp_addr.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
